// File: rtl/fp_addsub_pipe_if.sv
// fp_addsub_pipe_if: operand/result handshake bundle for the
// pipelined floating-point adder/subtractor.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         invalid;
    logic         inexact;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result,
        input  overflow, underflow, invalid, inexact
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result,
        output overflow, underflow, invalid, inexact
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-754 add/sub, round-to-nearest-even,
// subnormals flushed to zero, valid/ready on both sides.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_addsub_pipe_if.slave io_bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W+1:0] E_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);

    logic w_stall;
    assign w_stall = io_bus.out_valid & ~io_bus.out_ready;
    assign io_bus.in_ready = ~w_stall;

    logic             w_sa, w_sb, w_az, w_bz;
    logic [EXP_W-1:0] w_ea, w_eb, w_d;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [W-2:0]     w_amag, w_bmag, w_xmag, w_ymag;
    logic             w_swap, w_sx, w_sy;
    logic [MAN_W:0]   w_xsig, w_ysig;
    logic [SW-1:0]    w_yext, w_yal;
    logic             w_spec, w_sinv;
    logic [W-1:0]     w_sres;

    assign w_sa = io_bus.a[W-1];
    assign w_sb = io_bus.b[W-1] ^ io_bus.sub;
    assign w_ea = io_bus.a[W-2:MAN_W];
    assign w_eb = io_bus.b[W-2:MAN_W];
    assign w_fa = io_bus.a[MAN_W-1:0];
    assign w_fb = io_bus.b[MAN_W-1:0];
    assign w_az = (w_ea == '0);
    assign w_bz = (w_eb == '0);
    assign w_a_nan = (&w_ea) & (|w_fa);
    assign w_b_nan = (&w_eb) & (|w_fb);
    assign w_a_inf = (&w_ea) & ~(|w_fa);
    assign w_b_inf = (&w_eb) & ~(|w_fb);
    assign w_amag = w_az ? '0 : io_bus.a[W-2:0];
    assign w_bmag = w_bz ? '0 : io_bus.b[W-2:0];
    assign w_swap = (w_bmag > w_amag);
    assign w_xmag = w_swap ? w_bmag : w_amag;
    assign w_ymag = w_swap ? w_amag : w_bmag;
    assign w_sx   = w_swap ? w_sb : w_sa;
    assign w_sy   = w_swap ? w_sa : w_sb;
    assign w_xsig = {|w_xmag[W-2:MAN_W], w_xmag[MAN_W-1:0]};
    assign w_ysig = {|w_ymag[W-2:MAN_W], w_ymag[MAN_W-1:0]};
    assign w_d    = w_xmag[W-2:MAN_W] - w_ymag[W-2:MAN_W];
    assign w_yext = {w_ysig, 3'b000};

    // align smaller significand, folding shifted-out bits into sticky
    always_comb begin
        w_yal = '0;
        if (32'(w_d) >= 32'(MAN_W + 3))
            w_yal[0] = |w_ysig;
        else
            w_yal = (w_yext >> w_d)
                  | SW'(|(w_yext & ~({SW{1'b1}} << w_d)));
    end

    // special operands bypass the datapath with a fixed result
    always_comb begin
        w_sres = '0;
        w_sinv = 1'b0;
        w_spec = 1'b1;
        if (w_a_nan | w_b_nan
            | (w_a_inf & w_b_inf & (w_sa ^ w_sb))) begin
            w_sres = QNAN;
            w_sinv = 1'b1;
        end else if (w_a_inf)
            w_sres = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_b_inf)
            w_sres = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_az & w_bz)
            w_sres = {w_sa & w_sb, {(W-1){1'b0}}};
        else
            w_spec = 1'b0;
    end

    logic             r1_valid, r1_sign, r1_esub, r1_spec, r1_sinv;
    logic [EXP_W-1:0] r1_exp;
    logic [SW-1:0]    r1_mx, r1_my;
    logic [W-1:0]     r1_sres;

    // stage 1 register: aligned operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_esub  <= 1'b0;
            r1_spec  <= 1'b0;
            r1_sinv  <= 1'b0;
            r1_exp   <= '0;
            r1_mx    <= '0;
            r1_my    <= '0;
            r1_sres  <= '0;
        end else if (!w_stall) begin
            r1_valid <= io_bus.in_valid;
            r1_sign  <= w_sx;
            r1_esub  <= w_sx ^ w_sy;
            r1_spec  <= w_spec;
            r1_sinv  <= w_sinv;
            r1_exp   <= w_xmag[W-2:MAN_W];
            r1_mx    <= {w_xsig, 3'b000};
            r1_my    <= w_yal;
            r1_sres  <= w_sres;
        end
    end

    logic [SW:0]      w_sum;
    logic [SW-1:0]    w_dif, w_man2;
    logic [EXP_W+1:0] w_lz, w_exp2;
    logic             w_zero2, w_sign2;

    assign w_sum = {1'b0, r1_mx} + {1'b0, r1_my};
    assign w_dif = r1_mx - r1_my;

    // leading-zero count as a priority encoder (highest set bit wins)
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < SW; i++)
            if (w_dif[i]) w_lz = (EXP_W+2)'(SW - 1 - i);
    end

    // add or subtract magnitudes and renormalise
    always_comb begin
        w_exp2  = {2'b00, r1_exp};
        w_man2  = w_sum[SW-1:0];
        w_zero2 = 1'b0;
        w_sign2 = r1_sign;
        if (!r1_esub) begin
            if (w_sum[SW]) begin
                w_man2 = {w_sum[SW:2], |w_sum[1:0]};
                w_exp2 = w_exp2 + E_ONE;
            end
        end else begin
            w_man2 = w_dif << w_lz;
            w_exp2 = w_exp2 - w_lz;
            if (w_dif == '0) begin
                w_zero2 = 1'b1;
                w_sign2 = 1'b0;
            end
        end
    end

    logic             r2_valid, r2_sign, r2_zero, r2_spec, r2_sinv;
    logic [EXP_W+1:0] r2_exp;
    logic [SW-1:0]    r2_man;
    logic [W-1:0]     r2_sres;

    // stage 2 register: normalised sum with guard/round/sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_zero  <= 1'b0;
            r2_spec  <= 1'b0;
            r2_sinv  <= 1'b0;
            r2_exp   <= '0;
            r2_man   <= '0;
            r2_sres  <= '0;
        end else if (!w_stall) begin
            r2_valid <= r1_valid;
            r2_sign  <= w_sign2;
            r2_zero  <= w_zero2;
            r2_spec  <= r1_spec;
            r2_sinv  <= r1_sinv;
            r2_exp   <= w_exp2;
            r2_man   <= w_man2;
            r2_sres  <= r1_sres;
        end
    end

    logic [MAN_W:0]   w_m3;
    logic [MAN_W+1:0] w_rnd;
    logic [EXP_W+1:0] w_e3;
    logic [MAN_W-1:0] w_f3;
    logic             w_g, w_r, w_s, w_inc;
    logic [W-1:0]     w_res3;
    logic             w_ov3, w_un3, w_iv3, w_ix3;

    assign w_m3  = r2_man[SW-1:3];
    assign w_g   = r2_man[2];
    assign w_r   = r2_man[1];
    assign w_s   = r2_man[0];
    assign w_inc = w_g & (w_r | w_s | w_m3[0]);
    assign w_rnd = {1'b0, w_m3} + (MAN_W+2)'(w_inc);
    assign w_e3  = r2_exp + (EXP_W+2)'(w_rnd[MAN_W+1]);
    assign w_f3  = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1]
                                  : w_rnd[MAN_W-1:0];

    // round, range-check and pack
    always_comb begin
        w_res3 = {r2_sign, w_e3[EXP_W-1:0], w_f3};
        w_ov3  = 1'b0;
        w_un3  = 1'b0;
        w_iv3  = 1'b0;
        w_ix3  = w_g | w_r | w_s;
        if (r2_spec) begin
            w_res3 = r2_sres;
            w_iv3  = r2_sinv;
            w_ix3  = 1'b0;
        end else if (r2_zero) begin
            w_res3 = '0;
            w_ix3  = 1'b0;
        end else if ($signed(w_e3) >= $signed(E_MAX)) begin
            w_res3 = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ov3  = 1'b1;
            w_ix3  = 1'b1;
        end else if ($signed(w_e3) < $signed(E_ONE)) begin
            w_res3 = {r2_sign, {(W-1){1'b0}}};
            w_un3  = 1'b1;
            w_ix3  = 1'b1;
        end
    end

    // output register: holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_bus.out_valid <= 1'b0;
            io_bus.result    <= '0;
            io_bus.overflow  <= 1'b0;
            io_bus.underflow <= 1'b0;
            io_bus.invalid   <= 1'b0;
            io_bus.inexact   <= 1'b0;
        end else if (!w_stall) begin
            io_bus.out_valid <= r2_valid;
            if (r2_valid) begin
                io_bus.result    <= w_res3;
                io_bus.overflow  <= w_ov3;
                io_bus.underflow <= w_un3;
                io_bus.invalid   <= w_iv3;
                io_bus.inexact   <= w_ix3;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors for the pipelined FP adder,
// plus backpressure and mid-flight reset sequences.
module tb_fp_addsub_pipe;
    logic clk;
    logic rst_n;

    fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam logic [31:0] ONE = 32'h3F800000;

    vec_t        vecs[16];
    logic [31:0] bp_a[5];
    logic [31:0] bp_exp[5];
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({bus.overflow, bus.underflow,
                    bus.invalid, bus.inexact});
    endfunction

    task automatic run_op(input vec_t v, input string nm);
        int lat;
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.sub      = v.sub;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'd3);
        chk({nm, "_res"}, bus.result, v.res);
        chk({nm, "_flg"}, flags(), 32'(v.flg));
        @(posedge clk); #1;
    endtask

    initial begin
        int n_acc;
        int n_out;
        bit acc;
        int quiet;

        // flags are {overflow, underflow, invalid, inexact}
        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        vecs[2]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000};
        vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001};
        vecs[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0010};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010};
        vecs[8]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0101};
        vecs[9]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
        vecs[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
        vecs[11] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[12] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000};
        vecs[13] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
        vecs[14] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[15] = '{32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, 4'b0010};

        // 1..5 plus 1.0 gives 2..6
        bp_a   = '{32'h3F800000, 32'h40000000, 32'h40400000,
                   32'h40800000, 32'h40A00000};
        bp_exp = '{32'h40000000, 32'h40400000, 32'h40800000,
                   32'h40A00000, 32'h40C00000};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_flags", flags(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 16; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // backpressure: consumer blocked for the first 8 cycles
        n_acc = 0;
        n_out = 0;
        for (int c = 0; c < 40 && n_out < 5; c++) begin
            bus.out_ready = (c >= 8);
            bus.in_valid  = (n_acc < 5);
            if (n_acc < 5) begin
                bus.a   = bp_a[n_acc];
                bus.b   = ONE;
                bus.sub = 1'b0;
            end
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (c >= 3 && c < 8) begin
                chk($sformatf("bp_stall_rdy%0d", c),
                    32'(bus.in_ready), 32'd0);
                chk($sformatf("bp_stall_vld%0d", c),
                    32'(bus.out_valid), 32'd1);
                chk($sformatf("bp_stall_res%0d", c),
                    bus.result, bp_exp[0]);
            end
            if (c == 7)
                chk("bp_accepted_while_stalled", 32'(n_acc), 32'd3);
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("bp_out%0d", n_out),
                    bus.result, bp_exp[n_out]);
                n_out++;
            end
            @(posedge clk); #1;
            if (acc) n_acc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_n_out", 32'(n_out), 32'd5);
        chk("bp_n_acc", 32'(n_acc), 32'd5);
        quiet = 0;
        repeat (4) begin
            #1;
            if (bus.out_valid) quiet++;
            @(posedge clk); #1;
        end
        chk("bp_no_duplicate", 32'(quiet), 32'd0);

        // reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = bp_a[k];
            bus.b        = ONE;
            bus.sub      = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("rst2_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_result", bus.result, 32'd0);
        chk("rst2_flags", flags(), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        quiet = 0;
        repeat (4) begin
            if (bus.out_valid) quiet++;
            @(posedge clk); #1;
        end
        chk("rst2_no_stale", 32'(quiet), 32'd0);
        run_op('{32'h40000000, 32'h40400000, 1'b0,
                 32'h40A00000, 4'b0000}, "rst2_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754 adder/subtractor; successor to the single-precision combinational adder.
- Generic exponent and mantissa widths.
- Round-to-nearest-even; handles special values and raises exception flags.
- Three-stage pipeline with valid/ready handshake on both sides; sits between the operand-issue logic and the FP result writeback, alongside the divider datapath.

Parameters:
- EXP_W, 8, exponent field width (≥4).
- MAN_W, 23, stored fraction width (≥4); word width W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block accepts operands this cycle
- a  input  W  operand A {sign, exponent, fraction}
- b  input  W  operand B
- sub  input  1  1: compute a-b; 0: compute a+b
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- result  output  W  packed result
- overflow  output  1  result overflowed to infinity
- underflow  output  1  result flushed to zero from nonzero
- invalid  output  1  NaN produced from non-NaN operands, or NaN operand
- inexact  output  1  rounding discarded nonzero bits

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits and all output registers (out_valid=0, result=0, all flags=0). Reset mid-operation discards in-flight operations. in_ready=1 from the first cycle after release.
- Handshake:
  - Transfer occurs on in_valid&&in_ready and on out_valid&&out_ready.
  - Global stall = out_valid && !out_ready; all stages hold while stalled.
  - in_ready = !stall (combinational).
  - result and flags stay stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from accept to out_valid with no stall; throughput 1 per cycle; results in order.
- Stage 1, align:
  - Effective sign of B = b.sign ^ sub.
  - Subnormal inputs are treated as signed zero (flush-to-zero).
  - Swap so the larger magnitude (exponent, then fraction) is operand X.
  - Shift Y's significand {1,frac} right by the exponent difference, keeping guard, round and sticky bits. A difference ≥ MAN_W+3 leaves only sticky = (Y≠0).
- Stage 2, add/normalise:
  - Same effective signs: add; a carry shifts right 1 (shifted-out bit ORed into sticky) and increments the exponent.
  - Otherwise subtract Y from X. Normalise by leading-zero count (a priority encoder, not a loop) and decrement the exponent by the count.
  - An exact-zero difference gives +0.
- Stage 3, round/pack:
  - RNE: increment when G && (R||S||LSB).
  - A rounding carry renormalises and increments the exponent.
  - inexact = G|R|S.
  - Exponent ≥ all-ones → ±inf, overflow=1, inexact=1.
  - Biased exponent ≤ 0 → signed zero; underflow=1 and inexact=1 when the exact value was nonzero.
- Specials, detected in stage 1 and carried down the pipe:
  - Any NaN operand → canonical qNaN {0, all-ones, 1, zeros}, invalid=1.
  - inf + (−inf) effective → qNaN, invalid=1.
  - inf ± finite → that inf, no flags.
  - (−0)+(−0) effective → −0; other zero sums → +0.
- Flags are per-result and valid only with out_valid; they are not sticky.

Test Plan (EXP_W=8, MAN_W=23):
1. a=0x3F800000, b=0x40000000, sub=0 → after 3 cycles result=0x40400000, all flags 0.
2. a=0x3F800000, b=0x3F800000, sub=1 → 0x00000000, flags 0. a=0x80000000, b=0x00000000, sub=1 → 0x80000000.
3. Rounding: 0x3F800000+0x33800000 (tie, even LSB) → 0x3F800000, inexact=1. 0x3F800001+0x33800000 (tie, odd LSB) → 0x3F800002, inexact=1.
4. Specials:
   - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
   - 0x7F800000+0xFF800000 → 0x7FC00000, invalid=1.
   - 0x7FC00001+0x3F800000 → 0x7FC00000, invalid=1.
   - 0x00800001−0x00800000 → 0x00000000, underflow=1.
5. Backpressure: hold out_ready=0 and stream 5 operand pairs back-to-back → in_ready falls once the first result reaches the output register and stalls the pipe. result stays stable. Releasing out_ready delivers all 5 in order, none lost or duplicated.
6. Reset: assert rst_n=0 while 3 operations are in flight → out_valid=0 and result=0 immediately. After release, a new operation returns after exactly 3 cycles with no stale output.
